// File: rtl/truth_table_checker.sv
// Response checker for a 4-input boolean sweep: records observed F/G per minterm,
// tracks coverage, and latches pass or the first failure against expected truth tables.
//
// state   | meaning
// COLLECT | accepting observations, coverage incomplete, no error yet
// DONE    | all 16 minterms seen with no mismatch (sticky)
// FAIL    | first mismatch or ordering violation latched (sticky)
module truth_table_checker #(
    parameter logic [15:0] EXP_F   = 16'hF333,
    parameter logic [15:0] EXP_G   = 16'h0EE0,
    parameter bit          ORDERED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_vec,
    input  logic        in_f,
    input  logic        in_g,
    output logic [15:0] cov,
    output logic [15:0] obs_f,
    output logic [15:0] obs_g,
    output logic [7:0]  count,
    output logic        done,
    output logic        pass,
    output logic        err,
    output logic [3:0]  err_idx,
    output logic [1:0]  err_code,
    output logic        err_ord
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DONE    = 2'd1,
        FAIL    = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  exp_idx, exp_idx_nxt;
    logic [15:0] cov_nxt, obs_f_nxt, obs_g_nxt, cov_set;
    logic [7:0]  count_nxt;
    logic        err_nxt, err_ord_nxt;
    logic [3:0]  err_idx_nxt;
    logic [1:0]  err_code_nxt;
    logic        accept, f_mis, g_mis, ord_bad;

    assign accept  = in_valid && (state == COLLECT);
    assign f_mis   = (in_f != EXP_F[in_vec]);
    assign g_mis   = (in_g != EXP_G[in_vec]);
    assign ord_bad = ORDERED && (in_vec != exp_idx);
    assign cov_set = cov | (16'h0001 << in_vec);

    always_comb begin
        state_nxt    = state;
        cov_nxt      = cov;
        obs_f_nxt    = obs_f;
        obs_g_nxt    = obs_g;
        count_nxt    = count;
        exp_idx_nxt  = exp_idx;
        err_nxt      = err;
        err_idx_nxt  = err_idx;
        err_code_nxt = err_code;
        err_ord_nxt  = err_ord;

        if (clear) begin
            state_nxt    = COLLECT;
            cov_nxt      = '0;
            obs_f_nxt    = '0;
            obs_g_nxt    = '0;
            count_nxt    = '0;
            exp_idx_nxt  = '0;
            err_nxt      = 1'b0;
            err_idx_nxt  = '0;
            err_code_nxt = '0;
            err_ord_nxt  = 1'b0;
        end else if (accept) begin
            if (ord_bad) begin
                // out-of-order sample is rejected outright, nothing recorded
                state_nxt    = FAIL;
                err_nxt      = 1'b1;
                err_ord_nxt  = 1'b1;
                err_idx_nxt  = in_vec;
                err_code_nxt = 2'b00;
            end else begin
                cov_nxt           = cov_set;
                obs_f_nxt[in_vec] = in_f;
                obs_g_nxt[in_vec] = in_g;
                count_nxt         = (count == 8'hFF) ? count : count + 8'd1;
                exp_idx_nxt       = exp_idx + 4'd1;
                if (f_mis || g_mis) begin
                    state_nxt    = FAIL;
                    err_nxt      = 1'b1;
                    err_idx_nxt  = in_vec;
                    err_code_nxt = {g_mis, f_mis};
                end else if (cov_set == 16'hFFFF) begin
                    state_nxt = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COLLECT;
            in_ready <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            cov      <= '0;
            obs_f    <= '0;
            obs_g    <= '0;
            count    <= '0;
            exp_idx  <= '0;
            err      <= 1'b0;
            err_idx  <= '0;
            err_code <= '0;
            err_ord  <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == COLLECT);
            done     <= (state_nxt != COLLECT);
            pass     <= (state_nxt == DONE);
            cov      <= cov_nxt;
            obs_f    <= obs_f_nxt;
            obs_g    <= obs_g_nxt;
            count    <= count_nxt;
            exp_idx  <= exp_idx_nxt;
            err      <= err_nxt;
            err_idx  <= err_idx_nxt;
            err_code <= err_code_nxt;
            err_ord  <= err_ord_nxt;
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: an unordered and an ordered checker share one stimulus stream;
// a reference model pushes expected state per cycle and a monitor compares after each edge.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_vec = 4'd0;
    logic       in_f = 1'b0;
    logic       in_g = 1'b0;

    logic        r0_rdy, r0_done, r0_pass, r0_err, r0_eo;
    logic [15:0] r0_cov, r0_of, r0_og;
    logic [7:0]  r0_cnt;
    logic [3:0]  r0_ei;
    logic [1:0]  r0_ec;
    logic        r1_rdy, r1_done, r1_pass, r1_err, r1_eo;
    logic [15:0] r1_cov, r1_of, r1_og;
    logic [7:0]  r1_cnt;
    logic [3:0]  r1_ei;
    logic [1:0]  r1_ec;

    truth_table_checker #(.EXP_F(16'hF333), .EXP_G(16'h0EE0), .ORDERED(1'b0)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(r0_rdy),
        .in_vec(in_vec), .in_f(in_f), .in_g(in_g), .cov(r0_cov), .obs_f(r0_of),
        .obs_g(r0_og), .count(r0_cnt), .done(r0_done), .pass(r0_pass), .err(r0_err),
        .err_idx(r0_ei), .err_code(r0_ec), .err_ord(r0_eo));

    truth_table_checker #(.EXP_F(16'hF333), .EXP_G(16'h0EE0), .ORDERED(1'b1)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(r1_rdy),
        .in_vec(in_vec), .in_f(in_f), .in_g(in_g), .cov(r1_cov), .obs_f(r1_of),
        .obs_g(r1_og), .count(r1_cnt), .done(r1_done), .pass(r1_pass), .err(r1_err),
        .err_idx(r1_ei), .err_code(r1_ec), .err_ord(r1_eo));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cov;
        logic [15:0] obs_f;
        logic [15:0] obs_g;
        int          count;
        bit          done;
        bit          pass;
        bit          err;
        logic [3:0]  err_idx;
        logic [1:0]  err_code;
        bit          err_ord;
        int          exp_next;
    } model_t;

    int     checks = 0;
    int     failures = 0;
    model_t m0, m1, mon0, mon1;
    model_t q0[$];
    model_t q1[$];

    function automatic bit ref_f(logic [3:0] i);
        return (i[3] & i[2]) | ~i[1];
    endfunction

    function automatic bit ref_g(logic [3:0] i);
        return (i[3] ^ i[2]) & (i[1] | i[0]);
    endfunction

    function automatic model_t fresh();
        model_t m;
        m.cov = '0; m.obs_f = '0; m.obs_g = '0; m.count = 0;
        m.done = 0; m.pass = 0; m.err = 0; m.err_idx = '0; m.err_code = '0;
        m.err_ord = 0; m.exp_next = 0;
        return m;
    endfunction

    function automatic model_t step(model_t m, bit ordered, bit clr, bit v,
                                    logic [3:0] i, bit f, bit g);
        bit fm, gm;
        if (clr) return fresh();
        if (!v || m.done) return m;
        if (ordered && int'(i) != m.exp_next) begin
            m.done = 1; m.err = 1; m.err_ord = 1; m.err_idx = i; m.err_code = 2'b00;
            return m;
        end
        m.cov[i] = 1'b1;
        m.obs_f[i] = f;
        m.obs_g[i] = g;
        if (m.count < 255) m.count++;
        m.exp_next++;
        fm = (f != ref_f(i));
        gm = (g != ref_g(i));
        if (fm || gm) begin
            m.done = 1; m.err = 1; m.err_idx = i; m.err_code = {gm, fm};
        end else if (m.cov == 16'hFFFF) begin
            m.done = 1; m.pass = 1;
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input model_t m, input logic rdy,
                       input logic [15:0] cv, input logic [15:0] of, input logic [15:0] og,
                       input logic [7:0] cnt, input logic dn, input logic ps, input logic er,
                       input logic [3:0] ei, input logic [1:0] ec, input logic eo);
        check({tag, ".in_ready"}, rdy, !m.done);
        check({tag, ".cov"}, cv, m.cov);
        check({tag, ".obs_f"}, of, m.obs_f);
        check({tag, ".obs_g"}, og, m.obs_g);
        check({tag, ".count"}, cnt, m.count);
        check({tag, ".done"}, dn, m.done);
        check({tag, ".pass"}, ps, m.pass);
        check({tag, ".err"}, er, m.err);
        check({tag, ".err_idx"}, ei, m.err_idx);
        check({tag, ".err_code"}, ec, m.err_code);
        check({tag, ".err_ord"}, eo, m.err_ord);
    endtask

    task automatic cmp_both(input string tag);
        cmp({tag, ".u0"}, m0, r0_rdy, r0_cov, r0_of, r0_og, r0_cnt, r0_done, r0_pass,
            r0_err, r0_ei, r0_ec, r0_eo);
        cmp({tag, ".u1"}, m1, r1_rdy, r1_cov, r1_of, r1_og, r1_cnt, r1_done, r1_pass,
            r1_err, r1_ei, r1_ec, r1_eo);
    endtask

    always @(posedge clk) begin
        #1;
        if (q0.size() > 0 && q1.size() > 0) begin
            mon0 = q0.pop_front();
            mon1 = q1.pop_front();
            cmp("mon.u0", mon0, r0_rdy, r0_cov, r0_of, r0_og, r0_cnt, r0_done, r0_pass,
                r0_err, r0_ei, r0_ec, r0_eo);
            cmp("mon.u1", mon1, r1_rdy, r1_cov, r1_of, r1_og, r1_cnt, r1_done, r1_pass,
                r1_err, r1_ei, r1_ec, r1_eo);
        end
    end

    task automatic drive(input bit clr, input bit v, input logic [3:0] i, input bit f, input bit g);
        @(negedge clk);
        clear = clr; in_valid = v; in_vec = i; in_f = f; in_g = g;
        m0 = step(m0, 1'b0, clr, v, i, f, g);
        m1 = step(m1, 1'b1, clr, v, i, f, g);
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic good(input logic [3:0] i);
        drive(1'b0, 1'b1, i, ref_f(i), ref_g(i));
    endtask

    task automatic restart();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle();
    endtask

    // lets the edge after the last drive settle before direct spot checks
    task automatic settle();
        idle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] idx;
        bit         v, f, g;
        int         mode, nxt;

        m0 = fresh();
        m1 = fresh();
        #12;
        cmp_both("reset");
        @(negedge clk);
        rst = 1'b0;
        idle();

        // clean sweep
        for (int i = 0; i < 16; i++) good(4'(i));
        settle();
        check("sweep.pass", r0_pass, 1'b1);
        check("sweep.count", r0_cnt, 8'd16);
        check("sweep.obs_f", r0_of, 16'hF333);
        check("sweep.obs_g", r0_og, 16'h0EE0);
        check("sweep.in_ready", r0_rdy, 1'b0);
        restart();

        // F inverted at minterm 6, later samples must be ignored
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            drive(1'b0, 1'b1, idx, ref_f(idx) ^ (i == 6), ref_g(idx));
        end
        settle();
        check("fmis.err_idx", r0_ei, 4'd6);
        check("fmis.err_code", r0_ec, 2'b01);
        check("fmis.cov", r0_cov, 16'h007F);
        check("fmis.count", r0_cnt, 8'd7);
        restart();

        // duplicate of minterm 3 after 9
        for (int i = 0; i < 10; i++) good(4'(i));
        good(4'd3);
        for (int i = 10; i < 16; i++) good(4'(i));
        settle();
        check("dup.pass", r0_pass, 1'b1);
        check("dup.count", r0_cnt, 8'd17);
        restart();

        // duplicate of minterm 3 with G wrong
        for (int i = 0; i < 10; i++) good(4'(i));
        drive(1'b0, 1'b1, 4'd3, ref_f(4'd3), !ref_g(4'd3));
        settle();
        check("gdup.err_code", r0_ec, 2'b10);
        check("gdup.err_idx", r0_ei, 4'd3);
        restart();

        // ordering violation 0,1,3
        good(4'd0); good(4'd1); good(4'd3);
        settle();
        check("ord.err_ord", r1_eo, 1'b1);
        check("ord.err_idx", r1_ei, 4'd3);
        check("ord.cov", r1_cov, 16'h0003);
        check("ord.count", r1_cnt, 8'd2);
        restart();

        // asynchronous reset mid-sweep, then a fresh sweep
        for (int i = 0; i < 8; i++) good(4'(i));
        idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        m0 = fresh();
        m1 = fresh();
        cmp_both("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) good(4'(i));
        settle();
        check("post_rst.pass", r0_pass, 1'b1);
        check("post_rst.count", r0_cnt, 8'd16);
        restart();

        // clear wins over the completing sample
        for (int i = 0; i < 15; i++) good(4'(i));
        drive(1'b1, 1'b1, 4'd15, ref_f(4'd15), ref_g(4'd15));
        settle();
        check("clr.cov", r0_cov, 16'h0000);
        check("clr.count", r0_cnt, 8'd0);
        check("clr.in_ready", r0_rdy, 1'b1);
        check("clr.done", r0_done, 1'b0);
        restart();

        // count saturation via repeated minterm 0
        for (int i = 0; i < 300; i++) good(4'd0);
        settle();
        check("sat.count", r0_cnt, 8'd255);
        restart();

        // randomized rounds
        for (int r = 0; r < 30; r++) begin
            mode = int'($urandom_range(0, 1));
            nxt = 0;
            for (int c = 0; c < 40; c++) begin
                v = ($urandom_range(0, 3) != 0);
                idx = (mode == 1) ? 4'(nxt) : 4'($urandom_range(0, 15));
                if (mode == 1 && $urandom_range(0, 19) == 0) idx = 4'($urandom_range(0, 15));
                f = ref_f(idx) ^ ($urandom_range(0, 29) == 0);
                g = ref_g(idx) ^ ($urandom_range(0, 29) == 0);
                drive(1'b0, v, idx, f, g);
                if (v) nxt = (nxt + 1) % 16;
            end
            restart();
        end

        settle();
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", q0.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Response-side counterpart to the combinational boolean-expression stimulus sweep.
- Consumes strobed observation vectors {A,B,C,D,F,G} from a DUT under test and records the observed F/G value per minterm.
- Tracks coverage of all 16 minterms and compares each observation against parameterized expected truth tables.
- Reports pass when all 16 minterms are seen, or fail at the first mismatch with its index.

Parameters:
- EXP_F, 16'hF333, expected F truth table; bit i = F for {A,B,C,D}=i (F = A&B | ~C).
- EXP_G, 16'h0EE0, expected G truth table; bit i = G for {A,B,C,D}=i (G = (A^B)&(C|D)).
- ORDERED, 0, when 1 samples must arrive in strictly ascending minterm order 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous restart: same effect as reset.
- in_valid  input  1  observation present.
- in_ready  output  1  checker accepts; sample is taken when in_valid & in_ready.
- in_vec  input  4  {A,B,C,D}; minterm index.
- in_f  input  1  observed F.
- in_g  input  1  observed G.
- cov  output  16  bit i set once minterm i has been accepted.
- obs_f  output  16  last accepted F per minterm.
- obs_g  output  16  last accepted G per minterm.
- count  output  8  accepted samples; saturates at 255.
- done  output  1  sweep finished (pass or fail).
- pass  output  1  all 16 minterms seen, no errors.
- err  output  1  failure latched.
- err_idx  output  4  minterm of first failure.
- err_code  output  2  bit0 = F mismatch, bit1 = G mismatch.
- err_ord  output  1  failure was an ordering violation (ORDERED=1 only).

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except in_ready=1. FSM enters COLLECT.
- clear: synchronous, same result as reset. It has priority over a sample in the same cycle; that sample is dropped.
- FSM states: COLLECT, DONE, FAIL.
- in_ready is 1 only in COLLECT. It is registered and falls the cycle after the terminating sample.
- On an accepted sample with index i:
  - Set cov[i].
  - Write obs_f[i]=in_f and obs_g[i]=in_g.
  - Increment count, saturating at 255.
- Compare in_f against EXP_F[i] and in_g against EXP_G[i]:
  - On any mismatch, go to FAIL.
  - Latch err=1, err_idx=i, and err_code={g_mis,f_mis}.
  - The mismatching sample is still recorded in cov/obs/count.
- Ordering check (ORDERED=1):
  - Expected next index starts at 0 and increments per accept.
  - If i differs from the expected index, go to FAIL with err_ord=1, err_idx=i, err_code=00, and record nothing.
  - An ordering error takes precedence over a value mismatch.
- ORDERED=0: duplicates and any order are allowed. A duplicate overwrites obs and is re-checked against the expected tables.
- Completion: when the accepted sample makes cov==16'hFFFF with no error, go to DONE. In DONE: done=1, pass=1.
- FAIL outputs: done=1, pass=0. FAIL also takes precedence if the final minterm both mismatches and completes coverage.
- Latency: done/pass/err are visible on the cycle after the accepting edge.
- DONE and FAIL are sticky until rst or clear. in_valid is ignored there (no count change).
- Reset or clear mid-sweep clears all coverage, observations, count and the expected-index counter.

Test Plan:
- Sweep i=0..15 with correct F/G, one per cycle, ORDERED=0 -> the cycle after the 16th accept: done=1, pass=1, cov=FFFF, obs_f=F333, obs_g=0EE0, count=16, in_ready=0.
- Sweep with in_f inverted at i=6 -> err=1, err_idx=6, err_code=01, done=1, pass=0, cov=007F, count=7. Later samples are ignored.
- ORDERED=0, send 0..15 with minterm 3 repeated after 9, all correct -> pass=1, count=17. A repeat of 3 with in_g wrong -> err_code=10, err_idx=3.
- ORDERED=1, send 0,1,3 -> err=1, err_ord=1, err_idx=3, err_code=00, cov=0003, count=2.
- Assert rst asynchronously after 8 samples, release, then sweep again -> outputs 0 immediately; fresh sweep ends with pass=1, count=16.
- Pulse clear with in_valid in the same cycle at minterm 15 of an otherwise complete sweep -> sample dropped, cov=0, count=0, in_ready=1, done=0.
